// File: rtl/maxigp_fanout.sv
// One-to-NPORT AXI-style fanout: routes each AR/AW burst to the slave port picked by an address field.
// Read and write paths are independent FSMs, and each FSM carries one burst at a time.
module maxigp_fanout #(
  parameter int NPORT   = 4,
  parameter int SEL_LSB = 12,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 12,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  // upstream read address / write address / write data
  input  logic                    in_ar_ena,
  input  logic [ADDR_W-1:0]       in_ar_addr,
  input  logic [ID_W-1:0]         in_ar_id,
  input  logic [LEN_W-1:0]        in_ar_len,
  output logic                    in_ar_rdy,
  input  logic                    in_aw_ena,
  input  logic [ADDR_W-1:0]       in_aw_addr,
  input  logic [ID_W-1:0]         in_aw_id,
  input  logic [LEN_W-1:0]        in_aw_len,
  output logic                    in_aw_rdy,
  input  logic                    in_w_ena,
  input  logic [DATA_W-1:0]       in_w_data,
  input  logic [ID_W-1:0]         in_w_id,
  input  logic                    in_w_last,
  output logic                    in_w_rdy,
  // upstream responses
  output logic                    in_b_ena,
  output logic [ID_W-1:0]         in_b_id,
  output logic [1:0]              in_b_resp,
  input  logic                    in_b_rdy,
  output logic                    in_r_ena,
  output logic [DATA_W-1:0]       in_r_data,
  output logic [ID_W-1:0]         in_r_id,
  output logic                    in_r_last,
  output logic [1:0]              in_r_resp,
  input  logic                    in_r_rdy,
  // downstream ports
  output logic [NPORT-1:0]        out_ar_ena,
  output logic [ADDR_W-1:0]       out_ar_addr,
  output logic [ID_W-1:0]         out_ar_id,
  output logic [LEN_W-1:0]        out_ar_len,
  input  logic [NPORT-1:0]        out_ar_rdy,
  output logic [NPORT-1:0]        out_aw_ena,
  output logic [ADDR_W-1:0]       out_aw_addr,
  output logic [ID_W-1:0]         out_aw_id,
  output logic [LEN_W-1:0]        out_aw_len,
  input  logic [NPORT-1:0]        out_aw_rdy,
  output logic [NPORT-1:0]        out_w_ena,
  output logic [DATA_W-1:0]       out_w_data,
  output logic [ID_W-1:0]         out_w_id,
  output logic                    out_w_last,
  input  logic [NPORT-1:0]        out_w_rdy,
  input  logic [NPORT-1:0]        out_b_ena,
  input  logic [NPORT*ID_W-1:0]   out_b_id,
  input  logic [NPORT*2-1:0]      out_b_resp,
  output logic [NPORT-1:0]        out_b_rdy,
  input  logic [NPORT-1:0]        out_r_ena,
  input  logic [NPORT*DATA_W-1:0] out_r_data,
  input  logic [NPORT*ID_W-1:0]   out_r_id,
  input  logic [NPORT-1:0]        out_r_last,
  input  logic [NPORT*2-1:0]      out_r_resp,
  output logic [NPORT-1:0]        out_r_rdy,
  // FSM state for observation
  output logic [1:0]              r_state_dbg,
  output logic [2:0]              w_state_dbg
);
  // Handshake: ENA is valid, RDY is ready; a beat moves only on a cycle where both are 1,
  // and neither side may make its signal depend on the other being asserted first.
  localparam int SELW = $clog2(NPORT);
  localparam logic [SELW:0] PORT_LIM = (SELW+1)'(NPORT);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERRD, W_ERRB} w_state_t;

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
  logic [ID_W-1:0]   ar_id_q, aw_id_q;
  logic [LEN_W-1:0]  ar_len_q, aw_len_q;
  logic [SELW-1:0]   r_port, w_port, ar_sel, aw_sel;
  logic [LEN_W:0]    r_cnt;
  logic [NPORT-1:0]  r_onehot, w_onehot;
  logic              ar_bad, aw_bad, ar_fire, aw_fire, err_last;

  assign ar_sel   = in_ar_addr[SEL_LSB +: SELW];
  assign aw_sel   = in_aw_addr[SEL_LSB +: SELW];
  assign ar_bad   = {1'b0, ar_sel} >= PORT_LIM;
  assign aw_bad   = {1'b0, aw_sel} >= PORT_LIM;
  assign ar_fire  = in_ar_ena && (r_state == R_IDLE);
  assign aw_fire  = in_aw_ena && (w_state == W_IDLE);
  assign r_onehot = NPORT'(1) << r_port;
  assign w_onehot = NPORT'(1) << w_port;
  assign err_last = (r_cnt == {1'b0, ar_len_q});

  // Downstream request payloads come from registers, so they stay put however upstream behaves.
  assign out_ar_addr = ar_addr_q;
  assign out_ar_id   = ar_id_q;
  assign out_ar_len  = ar_len_q;
  assign out_aw_addr = aw_addr_q;
  assign out_aw_id   = aw_id_q;
  assign out_aw_len  = aw_len_q;
  assign out_w_data  = in_w_data;
  assign out_w_id    = in_w_id;
  assign out_w_last  = in_w_last;
  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      r_port    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        ar_addr_q <= in_ar_addr;
        ar_id_q   <= in_ar_id;
        ar_len_q  <= in_ar_len;
        r_port    <= ar_bad ? '0 : ar_sel;
        r_cnt     <= '0;
      end else if (r_state == R_ERR && in_r_rdy) begin
        r_cnt <= err_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    r_next     = r_state;
    in_ar_rdy  = 1'b0;
    out_ar_ena = '0;
    out_r_rdy  = '0;
    in_r_ena   = 1'b0;
    in_r_data  = '0;
    in_r_id    = '0;
    in_r_last  = 1'b0;
    in_r_resp  = '0;
    case (r_state)
      R_IDLE: begin
        in_ar_rdy = 1'b1;
        if (in_ar_ena) r_next = ar_bad ? R_ERR : R_ADDR;
      end
      R_ADDR: begin
        out_ar_ena = r_onehot;
        if (out_ar_rdy[r_port]) r_next = R_DATA;
      end
      R_DATA: begin
        in_r_ena  = out_r_ena[r_port];
        in_r_data = out_r_data[r_port*DATA_W +: DATA_W];
        in_r_id   = out_r_id[r_port*ID_W +: ID_W];
        in_r_last = out_r_last[r_port];
        in_r_resp = out_r_resp[r_port*2 +: 2];
        out_r_rdy = r_onehot & {NPORT{in_r_rdy}};
        if (out_r_ena[r_port] && in_r_rdy && out_r_last[r_port]) r_next = R_IDLE;
      end
      R_ERR: begin
        // Synthesise len+1 error beats so the master sees a complete burst.
        in_r_ena  = 1'b1;
        in_r_id   = ar_id_q;
        in_r_resp = 2'b11;
        in_r_last = err_last;
        if (in_r_rdy && err_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      aw_len_q  <= '0;
      w_port    <= '0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_addr_q <= in_aw_addr;
        aw_id_q   <= in_aw_id;
        aw_len_q  <= in_aw_len;
        w_port    <= aw_bad ? '0 : aw_sel;
      end
    end
  end

  always_comb begin
    w_next     = w_state;
    in_aw_rdy  = 1'b0;
    out_aw_ena = '0;
    out_w_ena  = '0;
    in_w_rdy   = 1'b0;
    in_b_ena   = 1'b0;
    in_b_id    = '0;
    in_b_resp  = '0;
    out_b_rdy  = '0;
    case (w_state)
      W_IDLE: begin
        in_aw_rdy = 1'b1;
        if (in_aw_ena) w_next = aw_bad ? W_ERRD : W_ADDR;
      end
      W_ADDR: begin
        out_aw_ena = w_onehot;
        if (out_aw_rdy[w_port]) w_next = W_DATA;
      end
      W_DATA: begin
        out_w_ena = w_onehot & {NPORT{in_w_ena}};
        in_w_rdy  = out_w_rdy[w_port];
        if (in_w_ena && out_w_rdy[w_port] && in_w_last) w_next = W_RESP;
      end
      W_RESP: begin
        in_b_ena  = out_b_ena[w_port];
        in_b_id   = out_b_id[w_port*ID_W +: ID_W];
        in_b_resp = out_b_resp[w_port*2 +: 2];
        out_b_rdy = w_onehot & {NPORT{in_b_rdy}};
        if (out_b_ena[w_port] && in_b_rdy) w_next = W_IDLE;
      end
      W_ERRD: begin
        // Swallow the orphaned write data, then answer with a decode error.
        in_w_rdy = 1'b1;
        if (in_w_ena && in_w_last) w_next = W_ERRB;
      end
      W_ERRB: begin
        in_b_ena  = 1'b1;
        in_b_id   = aw_id_q;
        in_b_resp = 2'b11;
        if (in_b_rdy) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_maxigp_fanout.sv
// Bench for maxigp_fanout: a 4-port instance for routing and a 3-port instance for decode errors.
// Upstream R beats are checked against an expected queue; other checks are inline in each test task.
module tb_maxigp_fanout;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors = 0;

  // 4-port instance
  logic ar_ena, ar_rdy, aw_ena, aw_rdy, w_ena, w_last, w_rdy;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [11:0] ar_id, aw_id, w_id;
  logic [3:0] ar_len, aw_len;
  logic b_ena, b_rdy, r_ena, r_last, r_rdy;
  logic [11:0] b_id, r_id;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data;
  logic [3:0] dar_ena, dar_rdy, daw_ena, daw_rdy, dw_ena, dw_rdy;
  logic [31:0] dar_addr, daw_addr, dw_data;
  logic [11:0] dar_id, daw_id, dw_id;
  logic [3:0] dar_len, daw_len;
  logic dw_last;
  logic [3:0] db_ena, db_rdy, dr_ena, dr_rdy, dr_last;
  logic [47:0] db_id, dr_id;
  logic [7:0] db_resp, dr_resp;
  logic [127:0] dr_data;
  logic [1:0] rs;
  logic [2:0] ws;

  // 3-port instance
  logic e_ar_ena, e_ar_rdy, e_aw_ena, e_aw_rdy, e_w_ena, e_w_last, e_w_rdy;
  logic [31:0] e_ar_addr, e_aw_addr, e_w_data;
  logic [11:0] e_ar_id, e_aw_id, e_w_id;
  logic [3:0] e_ar_len, e_aw_len;
  logic e_b_ena, e_b_rdy, e_r_ena, e_r_last, e_r_rdy;
  logic [11:0] e_b_id, e_r_id;
  logic [1:0] e_b_resp, e_r_resp;
  logic [31:0] e_r_data;
  logic [2:0] e_dar_ena, e_daw_ena, e_dw_ena, e_db_rdy, e_dr_rdy;
  logic [31:0] e_dar_addr, e_daw_addr, e_dw_data;
  logic [11:0] e_dar_id, e_daw_id, e_dw_id;
  logic [3:0] e_dar_len, e_daw_len;
  logic e_dw_last;
  logic [1:0] e_rs;
  logic [2:0] e_ws;

  logic [46:0] exp_q[$];
  logic [46:0] e_exp_q[$];
  logic [46:0] r_exp, e_exp;

  maxigp_fanout dut (
    .CLK(CLK), .nRST(nRST),
    .in_ar_ena(ar_ena), .in_ar_addr(ar_addr), .in_ar_id(ar_id), .in_ar_len(ar_len), .in_ar_rdy(ar_rdy),
    .in_aw_ena(aw_ena), .in_aw_addr(aw_addr), .in_aw_id(aw_id), .in_aw_len(aw_len), .in_aw_rdy(aw_rdy),
    .in_w_ena(w_ena), .in_w_data(w_data), .in_w_id(w_id), .in_w_last(w_last), .in_w_rdy(w_rdy),
    .in_b_ena(b_ena), .in_b_id(b_id), .in_b_resp(b_resp), .in_b_rdy(b_rdy),
    .in_r_ena(r_ena), .in_r_data(r_data), .in_r_id(r_id), .in_r_last(r_last), .in_r_resp(r_resp),
    .in_r_rdy(r_rdy),
    .out_ar_ena(dar_ena), .out_ar_addr(dar_addr), .out_ar_id(dar_id), .out_ar_len(dar_len),
    .out_ar_rdy(dar_rdy),
    .out_aw_ena(daw_ena), .out_aw_addr(daw_addr), .out_aw_id(daw_id), .out_aw_len(daw_len),
    .out_aw_rdy(daw_rdy),
    .out_w_ena(dw_ena), .out_w_data(dw_data), .out_w_id(dw_id), .out_w_last(dw_last), .out_w_rdy(dw_rdy),
    .out_b_ena(db_ena), .out_b_id(db_id), .out_b_resp(db_resp), .out_b_rdy(db_rdy),
    .out_r_ena(dr_ena), .out_r_data(dr_data), .out_r_id(dr_id), .out_r_last(dr_last),
    .out_r_resp(dr_resp), .out_r_rdy(dr_rdy),
    .r_state_dbg(rs), .w_state_dbg(ws)
  );

  maxigp_fanout #(.NPORT(3)) dut_err (
    .CLK(CLK), .nRST(nRST),
    .in_ar_ena(e_ar_ena), .in_ar_addr(e_ar_addr), .in_ar_id(e_ar_id), .in_ar_len(e_ar_len),
    .in_ar_rdy(e_ar_rdy),
    .in_aw_ena(e_aw_ena), .in_aw_addr(e_aw_addr), .in_aw_id(e_aw_id), .in_aw_len(e_aw_len),
    .in_aw_rdy(e_aw_rdy),
    .in_w_ena(e_w_ena), .in_w_data(e_w_data), .in_w_id(e_w_id), .in_w_last(e_w_last), .in_w_rdy(e_w_rdy),
    .in_b_ena(e_b_ena), .in_b_id(e_b_id), .in_b_resp(e_b_resp), .in_b_rdy(e_b_rdy),
    .in_r_ena(e_r_ena), .in_r_data(e_r_data), .in_r_id(e_r_id), .in_r_last(e_r_last),
    .in_r_resp(e_r_resp), .in_r_rdy(e_r_rdy),
    .out_ar_ena(e_dar_ena), .out_ar_addr(e_dar_addr), .out_ar_id(e_dar_id), .out_ar_len(e_dar_len),
    .out_ar_rdy(3'b111),
    .out_aw_ena(e_daw_ena), .out_aw_addr(e_daw_addr), .out_aw_id(e_daw_id), .out_aw_len(e_daw_len),
    .out_aw_rdy(3'b111),
    .out_w_ena(e_dw_ena), .out_w_data(e_dw_data), .out_w_id(e_dw_id), .out_w_last(e_dw_last),
    .out_w_rdy(3'b111),
    .out_b_ena(3'b000), .out_b_id(36'h0), .out_b_resp(6'h0), .out_b_rdy(e_db_rdy),
    .out_r_ena(3'b000), .out_r_data(96'h0), .out_r_id(36'h0), .out_r_last(3'b000),
    .out_r_resp(6'h0), .out_r_rdy(e_dr_rdy),
    .r_state_dbg(e_rs), .w_state_dbg(e_ws)
  );

  // Scoreboards: every upstream R transfer pops and compares the oldest expected beat.
  always @(negedge CLK) begin
    if (nRST && r_ena && r_rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL r_beat unexpected beat data=%h id=%h last=%b", r_data, r_id, r_last);
      end else begin
        r_exp = exp_q.pop_front();
        if ({r_data, r_id, r_last, r_resp} !== r_exp) begin
          errors++;
          $display("FAIL r_beat got %h want %h", {r_data, r_id, r_last, r_resp}, r_exp);
        end
      end
    end
    if (nRST && e_r_ena && e_r_rdy) begin
      vectors++;
      if (e_exp_q.size() == 0) begin
        errors++;
        $display("FAIL err_r_beat unexpected beat last=%b resp=%b", e_r_last, e_r_resp);
      end else begin
        e_exp = e_exp_q.pop_front();
        if ({e_r_data, e_r_id, e_r_last, e_r_resp} !== e_exp) begin
          errors++;
          $display("FAIL err_r_beat got %h want %h", {e_r_data, e_r_id, e_r_last, e_r_resp}, e_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len);
    ar_ena = 1'b1; ar_addr = a; ar_id = id; ar_len = len;
    @(negedge CLK);
    vectors++;
    if (ar_rdy !== 1'b1) begin errors++; $display("FAIL ar_accept got %b want 1", ar_rdy); end
    tick();
    ar_ena = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len);
    aw_ena = 1'b1; aw_addr = a; aw_id = id; aw_len = len;
    @(negedge CLK);
    vectors++;
    if (aw_rdy !== 1'b1) begin errors++; $display("FAIL aw_accept got %b want 1", aw_rdy); end
    tick();
    aw_ena = 1'b0;
  endtask

  // Present one R beat on port p (with junk on the other ports) and wait for it to move upstream.
  task automatic r_beat(input int p, input logic [31:0] d, input logic [11:0] id, input logic l,
                        input logic [1:0] rsp);
    int n;
    dr_ena = 4'b1111;
    dr_data = {4{~d}};
    dr_id = {4{~id}};
    dr_last = {4{~l}};
    dr_resp = {4{~rsp}};
    dr_data[p*32 +: 32] = d;
    dr_id[p*12 +: 12] = id;
    dr_last[p] = l;
    dr_resp[p*2 +: 2] = rsp;
    exp_q.push_back({d, id, l, rsp});
    n = 0;
    @(negedge CLK);
    while (!(r_ena && r_rdy) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (dr_rdy !== (4'b0001 << p)) begin
      errors++;
      $display("FAIL r_port_rdy got %b want %b", dr_rdy, 4'b0001 << p);
    end
    tick();
    dr_ena = '0;
  endtask

  task automatic w_beat(input int p, input logic [31:0] d, input logic l);
    w_ena = 1'b1; w_data = d; w_id = d[11:0]; w_last = l;
    @(negedge CLK);
    vectors++;
    if ({dw_ena, dw_data, dw_last, w_rdy} !== {4'b0001 << p, d, l, 1'b1}) begin
      errors++;
      $display("FAIL w_route got ena=%b data=%h last=%b rdy=%b want ena=%b data=%h last=%b rdy=1",
               dw_ena, dw_data, dw_last, w_rdy, 4'b0001 << p, d, l);
    end
    tick();
    w_ena = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    vectors++;
    if ({dar_ena, daw_ena, dw_ena, dr_rdy, db_rdy, r_ena, b_ena, rs, ws} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {dar_ena, daw_ena, dw_ena, dr_rdy, db_rdy, r_ena, b_ena, rs, ws});
    end
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({ar_rdy, aw_rdy, w_rdy, e_ar_rdy, e_aw_rdy, e_w_rdy} !== 6'b110110) begin
      errors++;
      $display("FAIL post_reset_rdy got %b want 110110", {ar_rdy, aw_rdy, w_rdy, e_ar_rdy, e_aw_rdy, e_w_rdy});
    end
    tick();
  endtask

  task automatic test_read_basic();
    send_ar(32'h2000, 12'd5, 4'd3);
    vectors++;
    if ({dar_ena, dar_addr, dar_id, dar_len, ar_rdy} !== {4'b0100, 32'h2000, 12'd5, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL ar_route got ena=%b addr=%h id=%h len=%h rdy=%b want 0100/2000/5/3/0",
               dar_ena, dar_addr, dar_id, dar_len, ar_rdy);
    end
    dar_rdy = 4'b1011;
    tick();
    vectors++;
    if ({dar_ena, dar_addr, rs} !== {4'b0100, 32'h2000, 2'd1}) begin
      errors++;
      $display("FAIL ar_hold got ena=%b addr=%h state=%0d want 0100/2000/1", dar_ena, dar_addr, rs);
    end
    dar_rdy = 4'b0100;
    tick();
    dar_rdy = '0;
    r_rdy = 1'b1;
    for (int i = 0; i < 4; i++) r_beat(2, $urandom, 12'd5, (i == 3), (i == 1) ? 2'b01 : 2'b00);
    vectors++;
    if ({ar_rdy, rs} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL read_done got rdy=%b state=%0d want 1/0", ar_rdy, rs);
    end
  endtask

  task automatic test_write_basic();
    send_aw(32'h1004, 12'd9, 4'd1);
    vectors++;
    if ({daw_ena, daw_addr, daw_len, aw_rdy, w_rdy} !== {4'b0010, 32'h1004, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL aw_route got ena=%b addr=%h len=%h awrdy=%b wrdy=%b want 0010/1004/1/0/0",
               daw_ena, daw_addr, daw_len, aw_rdy, w_rdy);
    end
    daw_rdy = 4'b0010;
    tick();
    daw_rdy = '0;
    dw_rdy = 4'b1101;
    w_ena = 1'b1; w_data = 32'hdead0000; w_last = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({dw_ena, w_rdy, ws} !== {4'b0010, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL w_stall got ena=%b rdy=%b state=%0d want 0010/0/2", dw_ena, w_rdy, ws);
    end
    tick();
    dw_rdy = 4'b0010;
    w_beat(1, $urandom, 1'b0);
    w_beat(1, $urandom, 1'b1);
    dw_rdy = '0;
    db_ena = 4'b0011;
    db_id = {24'h0, 12'd9, 12'hfff};
    db_resp = 8'b0000_0010;
    b_rdy = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({b_ena, b_id, b_resp, db_rdy, ws} !== {1'b1, 12'd9, 2'b00, 4'b0010, 3'd3}) begin
      errors++;
      $display("FAIL b_route got ena=%b id=%h resp=%b rdy=%b state=%0d want 1/9/00/0010/3",
               b_ena, b_id, b_resp, db_rdy, ws);
    end
    tick();
    b_rdy = 1'b0;
    db_ena = '0;
    vectors++;
    if ({ws, aw_rdy} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL write_done got state=%0d rdy=%b want 0/1", ws, aw_rdy);
    end
  endtask

  task automatic test_decode_err();
    int n;
    e_ar_ena = 1'b1; e_ar_addr = 32'h3000; e_ar_id = 12'd7; e_ar_len = 4'd2;
    tick();
    e_ar_ena = 1'b0;
    vectors++;
    if ({e_dar_ena, e_rs, e_ar_rdy} !== {3'b000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL ar_decode_err got ena=%b state=%0d rdy=%b want 000/3/0", e_dar_ena, e_rs, e_ar_rdy);
    end
    for (int i = 0; i < 3; i++) e_exp_q.push_back({32'h0, 12'd7, (i == 2), 2'b11});
    e_r_rdy = 1'b1;
    n = 0;
    while (e_exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    e_r_rdy = 1'b0;
    vectors++;
    if ({e_rs, e_ar_rdy, e_dr_rdy} !== {2'd0, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL err_read_done got state=%0d rdy=%b prdy=%b want 0/1/000", e_rs, e_ar_rdy, e_dr_rdy);
    end
    e_aw_ena = 1'b1; e_aw_addr = 32'h3000; e_aw_id = 12'd4; e_aw_len = 4'd0;
    tick();
    e_aw_ena = 1'b0;
    e_w_ena = 1'b1; e_w_data = 32'h1234; e_w_last = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({e_daw_ena, e_dw_ena, e_w_rdy, e_ws} !== {3'b000, 3'b000, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL w_decode_err got awena=%b wena=%b rdy=%b state=%0d want 000/000/1/4",
               e_daw_ena, e_dw_ena, e_w_rdy, e_ws);
    end
    tick();
    e_w_ena = 1'b0;
    vectors++;
    if ({e_b_ena, e_b_id, e_b_resp, e_ws} !== {1'b1, 12'd4, 2'b11, 3'd5}) begin
      errors++;
      $display("FAIL b_decode_err got ena=%b id=%h resp=%b state=%0d want 1/4/11/5",
               e_b_ena, e_b_id, e_b_resp, e_ws);
    end
    e_b_rdy = 1'b1;
    tick();
    e_b_rdy = 1'b0;
    vectors++;
    if ({e_ws, e_b_ena, e_db_rdy} !== {3'd0, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL err_write_done got state=%0d ena=%b prdy=%b want 0/0/000", e_ws, e_b_ena, e_db_rdy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    d = $urandom;
    send_ar(32'h1000, 12'h21, 4'd0);
    dar_rdy = 4'b0010;
    tick();
    dar_rdy = '0;
    r_rdy = 1'b0;
    dr_ena = 4'b0010; dr_data[32 +: 32] = d; dr_id[12 +: 12] = 12'h21; dr_last[1] = 1'b1; dr_resp[2 +: 2] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vectors++;
      if ({dr_rdy, r_ena, r_data} !== {4'b0000, 1'b1, d}) begin
        errors++;
        $display("FAIL r_stall cycle %0d got prdy=%b ena=%b data=%h want 0000/1/%h", i, dr_rdy, r_ena, r_data, d);
      end
      tick();
    end
    exp_q.push_back({d, 12'h21, 1'b1, 2'b00});
    r_rdy = 1'b1;
    tick();
    dr_ena = '0;
    send_aw(32'h3000, 12'h33, 4'd0);
    daw_rdy = 4'b1000;
    tick();
    daw_rdy = '0;
    dw_rdy = 4'b1000;
    w_beat(3, $urandom, 1'b1);
    dw_rdy = '0;
    b_rdy = 1'b0;
    db_ena = 4'b1000; db_id[36 +: 12] = 12'h33; db_resp[6 +: 2] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vectors++;
      if ({db_rdy, b_ena, b_id, b_resp} !== {4'b0000, 1'b1, 12'h33, 2'b10}) begin
        errors++;
        $display("FAIL b_stall cycle %0d got prdy=%b ena=%b id=%h resp=%b want 0000/1/33/10",
                 i, db_rdy, b_ena, b_id, b_resp);
      end
      tick();
    end
    b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    db_ena = '0;
    vectors++;
    if ({rs, ws} !== {2'd0, 3'd0}) begin
      errors++;
      $display("FAIL stall_done got rstate=%0d wstate=%0d want 0/0", rs, ws);
    end
  endtask

  task automatic test_same_port();
    ar_ena = 1'b1; ar_addr = 32'h0010; ar_id = 12'd1; ar_len = 4'd0;
    aw_ena = 1'b1; aw_addr = 32'h0020; aw_id = 12'd2; aw_len = 4'd0;
    @(negedge CLK);
    vectors++;
    if ({ar_rdy, aw_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL dual_accept got ar=%b aw=%b want 1/1", ar_rdy, aw_rdy);
    end
    tick();
    ar_ena = 1'b0; aw_ena = 1'b0;
    vectors++;
    if ({dar_ena, daw_ena, rs, ws} !== {4'b0001, 4'b0001, 2'd1, 3'd1}) begin
      errors++;
      $display("FAIL dual_route got ar=%b aw=%b rs=%0d ws=%0d want 0001/0001/1/1", dar_ena, daw_ena, rs, ws);
    end
    dar_rdy = 4'b0001; daw_rdy = 4'b0001;
    tick();
    dar_rdy = '0; daw_rdy = '0;
    r_beat(0, $urandom, 12'd1, 1'b1, 2'b00);
    vectors++;
    if ({rs, ws} !== {2'd0, 3'd2}) begin
      errors++;
      $display("FAIL independent got rs=%0d ws=%0d want 0/2", rs, ws);
    end
    dw_rdy = 4'b0001;
    w_beat(0, $urandom, 1'b1);
    dw_rdy = '0;
    db_ena = 4'b0001; db_id[0 +: 12] = 12'd2; db_resp[0 +: 2] = 2'b01; b_rdy = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({b_ena, b_id, b_resp} !== {1'b1, 12'd2, 2'b01}) begin
      errors++;
      $display("FAIL dual_b got ena=%b id=%h resp=%b want 1/2/01", b_ena, b_id, b_resp);
    end
    tick();
    b_rdy = 1'b0; db_ena = '0;
  endtask

  task automatic test_reset_mid();
    send_ar(32'h2000, 12'd6, 4'd3);
    dar_rdy = 4'b0100;
    tick();
    dar_rdy = '0;
    r_rdy = 1'b1;
    r_beat(2, $urandom, 12'd6, 1'b0, 2'b00);
    dr_ena = 4'b0100; dr_last = '0;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    vectors++;
    if ({r_ena, dr_rdy, dar_ena, rs} !== {1'b0, 4'b0000, 4'b0000, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid got ena=%b prdy=%b arena=%b state=%0d want 0/0000/0000/0", r_ena, dr_rdy, dar_ena, rs);
    end
    dr_ena = '0;
    tick();
    tick();
    nRST = 1'b1;
    send_ar(32'h1000, 12'd7, 4'd0);
    vectors++;
    if (dar_ena !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_ar got %b want 0010", dar_ena);
    end
    dar_rdy = 4'b0010;
    tick();
    dar_rdy = '0;
    r_beat(1, $urandom, 12'd7, 1'b1, 2'b10);
    vectors++;
    if (rs !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_done got %0d want 0", rs);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ar_ena = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
    aw_ena = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
    w_ena = 0; w_data = 0; w_id = 0; w_last = 0; b_rdy = 0; r_rdy = 0;
    dar_rdy = 0; daw_rdy = 0; dw_rdy = 0;
    db_ena = 0; db_id = 0; db_resp = 0;
    dr_ena = 0; dr_data = 0; dr_id = 0; dr_last = 0; dr_resp = 0;
    e_ar_ena = 0; e_ar_addr = 0; e_ar_id = 0; e_ar_len = 0;
    e_aw_ena = 0; e_aw_addr = 0; e_aw_id = 0; e_aw_len = 0;
    e_w_ena = 0; e_w_data = 0; e_w_id = 0; e_w_last = 0; e_b_rdy = 0; e_r_rdy = 0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_decode_err();
    test_backpressure();
    test_same_port();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0 || e_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got %0d/%0d want 0/0", exp_q.size(), e_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/maxigp_fanout.md
MAXIGP_FANOUT -- requirements
Module: maxigp_fanout

Interface
REQ-001 Parameter NPORT, default 4, meaning number of downstream slave ports (legal 2..8).
REQ-002 Parameter SEL_LSB, default 12, meaning lowest address bit of the port-select field; field width SELW = clog2(NPORT).
REQ-003 Parameter ADDR_W, default 32; ID_W, default 12; DATA_W, default 32; LEN_W, default 4.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK  in  1  sole clock, all state on rising edge.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 Upstream AR: in$AR__ENA in 1, in$AR$addr in ADDR_W, in$AR$id in ID_W, in$AR$len in LEN_W, in$AR__RDY out 1.
REQ-008 Upstream AW: in$AW__ENA in 1, in$AW$addr in ADDR_W, in$AW$id in ID_W, in$AW$len in LEN_W, in$AW__RDY out 1.
REQ-009 Upstream W: in$W__ENA in 1, in$W$data in DATA_W, in$W$id in ID_W, in$W$last in 1, in$W__RDY out 1.
REQ-010 Upstream B: in$B__ENA out 1, in$B$id out ID_W, in$B$resp out 2, in$B__RDY in 1.
REQ-011 Upstream R: in$R__ENA out 1, in$R$data out DATA_W, in$R$id out ID_W, in$R$last out 1, in$R$resp out 2, in$R__RDY in 1.
REQ-012 Downstream per port p: out$AR/AW/W__ENA out NPORT (one-hot), out$AR/AW/W__RDY in NPORT, out$B/R__ENA in NPORT, out$B/R__RDY out NPORT; payload fields broadcast (out) or packed NPORT*width (in).

Function
REQ-013 A transfer on any channel SHALL occur only in a cycle where ENA and RDY are both 1.
REQ-014 Port index SHALL be addr[SEL_LSB +: SELW]; index >= NPORT SHALL be a decode error.
REQ-015 Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR.
REQ-016 in$AR__RDY SHALL be 1 only in R_IDLE; on AR transfer addr/id/len/port SHALL be registered and state SHALL go to R_ADDR (valid port) or R_ERR (decode error).
REQ-017 In R_ADDR out$AR__ENA[port] SHALL be 1 with registered payload, held stable until out$AR__RDY[port]; then R_DATA.
REQ-018 In R_DATA in$R__ENA/payload SHALL mirror port's R channel and out$R__RDY[port] SHALL equal in$R__RDY, other ports 0; transfer with last=1 SHALL return to R_IDLE.
REQ-019 In R_ERR the block SHALL emit len+1 beats: data 0, id registered, resp 2'b11, last=1 only on final beat; beat counter LEN_W+1 bits, no wrap; then R_IDLE.
REQ-020 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERRD, W_ERRB.
REQ-021 in$AW__RDY SHALL be 1 only in W_IDLE; AW registered as for AR; valid port -> W_ADDR, error -> W_ERRD.
REQ-022 W_ADDR: out$AW__ENA[port] held until accepted -> W_DATA.
REQ-023 W_DATA: W passes through to port (in$W__RDY = out$W__RDY[port]); beat with last=1 -> W_RESP.
REQ-024 W_RESP: B mirrors port's B channel; upstream B transfer -> W_IDLE.
REQ-025 W_ERRD: in$W__RDY=1, beats discarded until last -> W_ERRB; W_ERRB: in$B__ENA=1, resp 2'b11, id registered, until accepted -> W_IDLE.
REQ-026 in$W__RDY SHALL be 0 outside W_DATA/W_ERRD (W before AW stalls).
REQ-027 Read and write FSMs SHALL be independent; simultaneous AR and AW in W_IDLE/R_IDLE SHALL both be accepted in the same cycle, including to the same port.
REQ-028 Minimum latency: AR accept to out$AR__ENA = 1 cycle; R/W/B data paths combinational, zero added cycles.
REQ-029 Upstream ENA dropping before RDY SHALL NOT be assumed; registered payload makes downstream stable regardless.

Reset
REQ-030 nRST low SHALL immediately force R_IDLE, W_IDLE, all out ENA/RDY and in$B/R__ENA to 0, counters to 0, registered payloads to 0, mid-burst included.
REQ-031 First cycle after nRST release: in$AR__RDY=1, in$AW__RDY=1, in$W__RDY=0.

Verification
REQ-032 AR addr 0x2000 id 5 len 3 (NPORT 4, SEL_LSB 12) -> out$AR__ENA=0b0100 next cycle; 4 port-2 R beats forwarded, in$AR__RDY back to 1 after last.
REQ-033 AW addr 0x1004 len 1, 2 W beats, port-1 B resp 0 -> W routed only to port 1, in$B resp 0 id matches, FSM W_IDLE.
REQ-034 NPORT 3, AR addr 0x3000 len 2 -> no downstream ENA; 3 R beats data 0 resp 3, last on 3rd; AW 0x3000 + 1 W beat -> B resp 3.
REQ-035 in$R__RDY/in$B__RDY held 0 for 5 cycles -> port RDY 0, payload stable, no beats lost.
REQ-036 Simultaneous AR to port 0 and AW to port 0 -> both accepted same cycle, transactions complete independently.
REQ-037 nRST asserted mid R burst (beat 2 of 4) -> all ENA 0 same cycle; after release new AR accepted normally.
